// File: rtl/write_through_buffer_pkg.sv
// Shared defaults and helper types for the write-through buffer.
package write_through_buffer_pkg;

  localparam int unsigned DEF_FE_ADDR_W = 32;
  localparam int unsigned DEF_FE_DATA_W = 32;
  localparam int unsigned DEF_DEPTH_W   = 2;
  localparam int unsigned BYTE_W        = 8;

  // Occupancy change for one cycle, encoded as {push, pop}.
  typedef enum logic [1:0] {
    LVL_HOLD = 2'b00,
    LVL_DEC  = 2'b01,
    LVL_INC  = 2'b10,
    LVL_BOTH = 2'b11
  } lvl_op_e;

endpackage

// File: rtl/write_through_buffer_mem.sv
// Entry storage: one synchronous write port with per-field enables, one async read port,
// plus every stored address flattened for the hazard compare.
module write_through_buffer_mem
  import write_through_buffer_pkg::*;
#(
  parameter int unsigned ADDR_W  = 30,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NBYTES  = DATA_W / 8,
  parameter int unsigned DEPTH_W = 2
) (
  input  logic                              clk,
  input  logic                              i_we,
  input  logic [DEPTH_W-1:0]                i_widx,
  input  logic                              i_addr_we,
  input  logic [NBYTES-1:0]                 i_byte_we,
  input  logic                              i_strb_merge,
  input  logic [ADDR_W-1:0]                 i_addr,
  input  logic [DATA_W-1:0]                 i_data,
  input  logic [NBYTES-1:0]                 i_strb,
  input  logic [DEPTH_W-1:0]                i_ridx,
  output logic [ADDR_W-1:0]                 o_addr,
  output logic [DATA_W-1:0]                 o_data,
  output logic [NBYTES-1:0]                 o_strb,
  output logic [(2**DEPTH_W)*ADDR_W-1:0]    o_addr_flat
);

  localparam int unsigned DEPTH = 2 ** DEPTH_W;

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [NBYTES-1:0] r_strb [DEPTH];

  // Contents are don't-care after reset, so storage carries no reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      if (i_addr_we) r_addr[i_widx] <= i_addr;
      for (int b = 0; b < int'(NBYTES); b++) begin
        if (i_byte_we[b]) r_data[i_widx][b*BYTE_W +: BYTE_W] <= i_data[b*BYTE_W +: BYTE_W];
      end
      r_strb[i_widx] <= i_strb_merge ? (r_strb[i_widx] | i_strb) : i_strb;
    end
  end

  assign o_addr = r_addr[i_ridx];
  assign o_data = r_data[i_ridx];
  assign o_strb = r_strb[i_ridx];

  always_comb begin
    o_addr_flat = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      o_addr_flat[i*ADDR_W +: ADDR_W] = r_addr[i];
    end
  end

endmodule

// File: rtl/write_through_buffer.sv
// Write-through FIFO in front of the native write channel with youngest-entry merging
// and a read-after-write hazard flag.
module write_through_buffer
  import write_through_buffer_pkg::*;
#(
  parameter int unsigned FE_ADDR_W = DEF_FE_ADDR_W,
  parameter int unsigned FE_DATA_W = DEF_FE_DATA_W,
  parameter int unsigned FE_NBYTES = FE_DATA_W / 8,
  parameter int unsigned FE_BYTE_W = $clog2(FE_NBYTES),
  parameter int unsigned DEPTH_W   = DEF_DEPTH_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_valid,
  input  logic [FE_ADDR_W-1:FE_BYTE_W] wr_addr,
  input  logic [FE_DATA_W-1:0]         wr_wdata,
  input  logic [FE_NBYTES-1:0]         wr_wstrb,
  output logic                         wr_ready,
  output logic                         out_valid,
  output logic [FE_ADDR_W-1:FE_BYTE_W] out_addr,
  output logic [FE_DATA_W-1:0]         out_wdata,
  output logic [FE_NBYTES-1:0]         out_wstrb,
  input  logic                         out_ready,
  input  logic [FE_ADDR_W-1:FE_BYTE_W] rd_addr,
  output logic                         rd_hazard,
  output logic                         empty,
  output logic                         full,
  output logic [DEPTH_W:0]             level
);

  localparam int unsigned AW      = FE_ADDR_W - FE_BYTE_W;
  localparam int unsigned DEPTH   = 2 ** DEPTH_W;
  localparam int unsigned ENTRY_W = AW + FE_DATA_W + FE_NBYTES;

  logic [DEPTH_W-1:0]  r_rd_ptr, r_wr_ptr;
  logic [DEPTH_W:0]    r_level;
  logic                r_empty, r_full;

  logic [DEPTH_W-1:0]  w_young;
  logic [AW-1:0]       w_ent_addr [DEPTH];
  logic [DEPTH_W-1:0]  w_off [DEPTH];
  logic [DEPTH*AW-1:0] w_addr_flat;
  logic                w_merge, w_push, w_pop;
  logic [DEPTH_W:0]    w_level_nxt;
  lvl_op_e             w_op;

  assign w_young = r_wr_ptr - DEPTH_W'(1);
  assign w_merge = wr_valid & ~r_full & (r_level >= (DEPTH_W+1)'(2))
                 & (wr_addr == w_ent_addr[w_young]);
  assign w_push  = wr_valid & ~r_full & ~w_merge;
  assign w_pop   = out_ready & ~r_empty;
  assign w_op    = lvl_op_e'({w_push, w_pop});

  always_comb begin
    w_level_nxt = r_level;
    case (w_op)
      LVL_INC:  w_level_nxt = r_level + (DEPTH_W+1)'(1);
      LVL_DEC:  w_level_nxt = r_level - (DEPTH_W+1)'(1);
      LVL_HOLD: w_level_nxt = r_level;
      LVL_BOTH: w_level_nxt = r_level;
      default:  w_level_nxt = r_level;
    endcase
  end

  // Pointers, level and the registered full/empty flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_level  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + DEPTH_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + DEPTH_W'(1);
      r_level <= w_level_nxt;
      r_empty <= (w_level_nxt == '0);
      r_full  <= (w_level_nxt == (DEPTH_W+1)'(DEPTH));
    end
  end

  write_through_buffer_mem #(
    .ADDR_W  (AW),
    .DATA_W  (FE_DATA_W),
    .NBYTES  (FE_NBYTES),
    .DEPTH_W (DEPTH_W)
  ) u_mem (
    .clk          (clk),
    .i_we         (w_push | w_merge),
    .i_widx       (w_merge ? w_young : r_wr_ptr),
    .i_addr_we    (w_push),
    .i_byte_we    (w_push ? {FE_NBYTES{1'b1}} : wr_wstrb),
    .i_strb_merge (w_merge),
    .i_addr       (wr_addr),
    .i_data       (wr_wdata),
    .i_strb       (wr_wstrb),
    .i_ridx       (r_rd_ptr),
    .o_addr       (out_addr),
    .o_data       (out_wdata),
    .o_strb       (out_wstrb),
    .o_addr_flat  (w_addr_flat)
  );

  // An entry is occupied when its distance from the head is below the level.
  always_comb begin
    rd_hazard = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      w_ent_addr[i] = w_addr_flat[i*AW +: AW];
      w_off[i]      = DEPTH_W'(i) - r_rd_ptr;
      if (({1'b0, w_off[i]} < r_level) && (w_ent_addr[i] == rd_addr)) rd_hazard = 1'b1;
    end
  end

  assign wr_ready  = ~r_full;
  assign out_valid = ~r_empty;
  assign empty     = r_empty;
  assign full      = r_full;
  assign level     = r_level;

  logic unused_entry_w;
  assign unused_entry_w = ^(ENTRY_W);

endmodule

// File: tb/tb_write_through_buffer.sv
// Directed plus randomized bench for write_through_buffer against a queue-based model.
module tb_write_through_buffer;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_valid;
  logic [31:2] wr_addr;
  logic [31:0] wr_wdata;
  logic [3:0]  wr_wstrb;
  logic        wr_ready;
  logic        out_valid;
  logic [31:2] out_addr;
  logic [31:0] out_wdata;
  logic [3:0]  out_wstrb;
  logic        out_ready;
  logic [31:2] rd_addr;
  logic        rd_hazard;
  logic        empty;
  logic        full;
  logic [2:0]  level;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } ent_t;

  ent_t q[$];

  write_through_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_wdata  (wr_wdata),
    .wr_wstrb  (wr_wstrb),
    .wr_ready  (wr_ready),
    .out_valid (out_valid),
    .out_addr  (out_addr),
    .out_wdata (out_wdata),
    .out_wstrb (out_wstrb),
    .out_ready (out_ready),
    .rd_addr   (rd_addr),
    .rd_hazard (rd_hazard),
    .empty     (empty),
    .full      (full),
    .level     (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs follow directly from the list of pending entries.
  task automatic compare_all();
    bit haz;
    haz = 1'b0;
    foreach (q[i]) if (q[i].addr == rd_addr) haz = 1'b1;
    check("level", 64'(level), 64'(q.size()));
    check("empty", 64'(empty), 64'(q.size() == 0));
    check("full", 64'(full), 64'(q.size() == DEPTH));
    check("wr_ready", 64'(wr_ready), 64'(q.size() != DEPTH));
    check("out_valid", 64'(out_valid), 64'(q.size() != 0));
    check("rd_hazard", 64'(rd_hazard), 64'(haz));
    if (q.size() != 0) begin
      check("out_addr", 64'(out_addr), 64'(q[0].addr));
      check("out_wdata", 64'(out_wdata), 64'(q[0].data));
      check("out_wstrb", 64'(out_wstrb), 64'(q[0].strb));
    end
  endtask

  task automatic model_update();
    bit   is_full, do_merge, do_pop, do_push;
    ent_t e;
    is_full  = (q.size() == DEPTH);
    do_merge = wr_valid && !is_full && q.size() >= 2 && q[q.size()-1].addr == wr_addr;
    do_pop   = out_ready && q.size() != 0;
    do_push  = wr_valid && !is_full && !do_merge;
    if (do_merge) begin
      e = q[q.size()-1];
      for (int b = 0; b < 4; b++) if (wr_wstrb[b]) e.data[b*8 +: 8] = wr_wdata[b*8 +: 8];
      e.strb = e.strb | wr_wstrb;
      q[q.size()-1] = e;
    end
    if (do_pop) void'(q.pop_front());
    if (do_push) begin
      e.addr = wr_addr; e.data = wr_wdata; e.strb = wr_wstrb;
      q.push_back(e);
    end
  endtask

  // Inputs are set before calling; check mid-cycle, clock, update the model.
  task automatic step();
    #2;
    compare_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input bit v, input logic [29:0] a, input logic [31:0] d,
                       input logic [3:0] s, input bit rdy);
    wr_valid = v; wr_addr = a; wr_wdata = d; wr_wstrb = s; out_ready = rdy;
  endtask

  task automatic drain();
    drive(0, '0, '0, '0, 1);
    for (int i = 0; i < 6; i++) step();
    out_ready = 0;
  endtask

  initial begin
    reset = 1'b0;
    drive(0, '0, '0, '0, 0);
    rd_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_level", 64'(level), 64'd0);
    check("reset_empty", 64'(empty), 64'd1);
    check("reset_wr_ready", 64'(wr_ready), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;

    // Asynchronous reset in the middle of traffic.
    for (int i = 0; i < 3; i++) begin drive(1, 30'h50 + 30'(i), 32'h1000 + i, 4'hF, 0); step(); end
    drive(0, '0, '0, '0, 0);
    rd_addr = 30'h50;
    #1;
    check("pre_reset_hazard", 64'(rd_hazard), 64'd1);
    reset = 1'b0;
    #1;
    q.delete();
    check("async_empty", 64'(empty), 64'd1);
    check("async_level", 64'(level), 64'd0);
    check("async_out_valid", 64'(out_valid), 64'd0);
    check("async_hazard", 64'(rd_hazard), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Fill then drain in order.
    for (int i = 0; i < 4; i++) begin drive(1, 30'h10 + 30'(i), 32'hA0 + i, 4'hF, 0); step(); end
    drive(0, '0, '0, '0, 0);
    #1;
    check("fill_full", 64'(full), 64'd1);
    check("fill_wr_ready", 64'(wr_ready), 64'd0);
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("drain_data", 64'(out_wdata), 64'hA0 + 64'(i));
      step();
    end
    check("drain_empty", 64'(empty), 64'd1);

    // Wrap-around with one push and one pop per cycle.
    drive(1, 30'h60, 32'hC0, 4'hF, 0); step();
    for (int i = 1; i <= 10; i++) begin
      drive(1, 30'h60 + 30'(i), 32'hC0 + i, 4'hF, 1);
      #1;
      check("wrap_level_le2", 64'(level <= 3'd2), 64'd1);
      check("wrap_order", 64'(out_wdata), 64'hC0 + 64'(i - 1));
      step();
    end
    drain();

    // Merge into the youngest entry only.
    drive(1, 30'h20, 32'h11111111, 4'h1, 0); step();
    drive(1, 30'h24, 32'h22222222, 4'hF, 0); step();
    drive(1, 30'h24, 32'h000000BB, 4'h1, 0); step();
    drive(0, '0, '0, '0, 0); #1;
    check("merge_level", 64'(level), 64'd2);
    drive(1, 30'h20, 32'h33333333, 4'hF, 0); step();
    drive(0, '0, '0, '0, 1); #1;
    check("nomerge_level", 64'(level), 64'd3);
    step();
    #1;
    check("merge_data", 64'(out_wdata), 64'h222222BB);
    check("merge_strb", 64'(out_wstrb), 64'hF);
    drain();

    // Push+pop at level 3, then pop while full.
    for (int i = 0; i < 3; i++) begin drive(1, 30'h70 + 30'(i), 32'hE0 + i, 4'hF, 0); step(); end
    drive(1, 30'h78, 32'hE8, 4'hF, 1); step();
    check("pushpop_level", 64'(level), 64'd3);
    drive(1, 30'h79, 32'hE9, 4'hF, 0); step();
    drive(0, '0, '0, '0, 1); #1;
    check("full_pop_ready_same", 64'(wr_ready), 64'd0);
    step();
    check("full_pop_ready_next", 64'(wr_ready), 64'd1);
    drain();

    // Hazard covers the head during its pop cycle.
    drive(1, 30'h30, 32'h1, 4'hF, 0); step();
    drive(1, 30'h34, 32'h2, 4'hF, 0); step();
    drive(0, '0, '0, '0, 0);
    rd_addr = 30'h34; #1;
    check("haz_hit", 64'(rd_hazard), 64'd1);
    rd_addr = 30'h38; #1;
    check("haz_miss", 64'(rd_hazard), 64'd0);
    rd_addr = 30'h30; out_ready = 1; #1;
    check("haz_pop_cycle", 64'(rd_hazard), 64'd1);
    step();
    out_ready = 0; #1;
    check("haz_after_pop", 64'(rd_hazard), 64'd0);
    drain();

    // Randomized traffic on a small address set to exercise merges and hazards.
    for (int n = 0; n < 400; n++) begin
      drive((q.size() < DEPTH) && ($urandom_range(0, 3) != 0),
            30'h40 + 30'($urandom_range(0, 2)), $urandom(),
            4'($urandom_range(1, 15)), $urandom_range(0, 2) == 0);
      rd_addr = 30'h40 + 30'($urandom_range(0, 3));
      step();
    end
    drain();
    compare_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
